// File: rtl/ysyx_25040105_pkg.sv
// Shared types and constants for the multi-cycle NPC core.
// Contents: FSM state enum, ALU op enum, operand-B select enum, RV32I opcode
// and funct constants, the ebreak encoding and the default reset PC.
package ysyx_25040105_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } state_e;

    typedef enum logic [0:0] {
        ALU_ADD    = 1'b0,
        ALU_PASS_B = 1'b1
    } alu_op_e;

    typedef enum logic [1:0] {
        OPB_RS2   = 2'd0,
        OPB_IMM_I = 2'd1,
        OPB_IMM_U = 2'd2
    } opb_sel_e;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] SYSTEM = 7'b1110011;

    localparam logic [2:0]  F3_ADD      = 3'b000;
    localparam logic [6:0]  F7_ADD      = 7'b0000000;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

endpackage

// File: rtl/ysyx_25040105_regfile.sv
// Architectural register file.
// Ports: clk; write port (we, waddr, wdata); two read ports (raddr1/rdata1,
// raddr2/rdata2); debug read port (dbg_raddr/dbg_rdata). All reads are
// combinational; x0 and any index >= NR_REGS read as zero.
module ysyx_25040105_regfile
    import ysyx_25040105_pkg::*;
#(
    parameter int unsigned NR_REGS = 32,
    parameter int unsigned XLEN    = 32
) (
    input  logic            clk,
    input  logic            we,
    input  logic [4:0]      waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [4:0]      raddr1,
    output logic [XLEN-1:0] rdata1,
    input  logic [4:0]      raddr2,
    output logic [XLEN-1:0] rdata2,
    input  logic [4:0]      dbg_raddr,
    output logic [XLEN-1:0] dbg_rdata
);

    localparam int unsigned AW = $clog2(NR_REGS);

    // Contents are intentionally not reset; entry 0 is never written and
    // always masked on read, which is what makes x0 a hard zero.
    logic [XLEN-1:0] regs_q [NR_REGS];

    always_ff @(posedge clk) begin
        if (we && (waddr != 5'd0) && (int'(waddr) < NR_REGS)) begin
            regs_q[waddr[AW-1:0]] <= wdata;
        end
    end

    assign rdata1 = ((raddr1 == 5'd0) || (int'(raddr1) >= NR_REGS)) ? '0 : regs_q[raddr1[AW-1:0]];
    assign rdata2 = ((raddr2 == 5'd0) || (int'(raddr2) >= NR_REGS)) ? '0 : regs_q[raddr2[AW-1:0]];
    assign dbg_rdata = ((dbg_raddr == 5'd0) || (int'(dbg_raddr) >= NR_REGS)) ? '0
                                                                             : regs_q[dbg_raddr[AW-1:0]];

endmodule

// File: rtl/ysyx_25040105_core_mc.sv
// Multi-cycle RV32I/RV32E-subset core (addi, add, lui, auipc, jal, jalr, ebreak).
// Ports: clk, rst_n (async active-low); instruction fetch handshake
// (imem_req/imem_addr/imem_ready out-in, imem_rvalid/imem_rdata in);
// debug register read (dbg_raddr/dbg_rdata); halt status (halt, halt_illegal,
// halt_code = a0 at halt); retire trace (commit_valid/commit_pc/commit_inst).
// Build option: YSYX_25040105_COMMIT_TRACE_EN drives the commit_* ports;
// without it they are tied to zero.
//
// state | meaning
// FETCH | imem_req high with imem_addr = pc, waiting for imem_ready
// WAIT  | request accepted, waiting for the imem_rvalid pulse to load IR
// EXEC  | decode/execute IR, write rd, update pc, report commit
// HALT  | stopped after ebreak or illegal instruction, until reset
module ysyx_25040105_core_mc
    import ysyx_25040105_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NR_REGS  = 32,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    input  logic [4:0]      dbg_raddr,
    output logic [XLEN-1:0] dbg_rdata,
    output logic            halt,
    output logic            halt_illegal,
    output logic [XLEN-1:0] halt_code,
    output logic            commit_valid,
    output logic [XLEN-1:0] commit_pc,
    output logic [31:0]     commit_inst
);

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     ir_q, ir_d;
    logic            halt_illegal_q, halt_illegal_d;
    logic [XLEN-1:0] halt_code_q, halt_code_d;

    logic [6:0]      opcode, funct7;
    logic [4:0]      rd, rs1, rs2, rf_raddr2;
    logic [2:0]      funct3;
    logic [XLEN-1:0] imm_i, imm_u, imm_j;
    logic [XLEN-1:0] rs1_data, rs2_data;

    logic            dec_ok, reg_ok, use_rs1, use_rs2, use_rd;
    logic            a_sel_pc, is_jal, is_jalr, is_ebreak;
    alu_op_e         alu_op;
    opb_sel_e        opb_sel;

    logic [XLEN-1:0] op_a, op_b, alu_res, pc_plus4, jalr_sum, jmp_tgt, wb_data;
    logic            misalign, legal, exec, rf_we;

    assign opcode = ir_q[6:0];
    assign rd     = ir_q[11:7];
    assign funct3 = ir_q[14:12];
    assign rs1    = ir_q[19:15];
    assign rs2    = ir_q[24:20];
    assign funct7 = ir_q[31:25];
    assign imm_i  = {{20{ir_q[31]}}, ir_q[31:20]};
    assign imm_u  = {ir_q[31:12], 12'b0};
    assign imm_j  = {{12{ir_q[31]}}, ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};

    // Static decode: depends on IR only, never on register data.
    always_comb begin
        dec_ok    = 1'b0;
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        use_rd    = 1'b0;
        a_sel_pc  = 1'b0;
        is_jal    = 1'b0;
        is_jalr   = 1'b0;
        is_ebreak = 1'b0;
        alu_op    = ALU_ADD;
        opb_sel   = OPB_IMM_I;
        unique case (opcode)
            OP_IMM: begin
                dec_ok  = (funct3 == F3_ADD);
                use_rs1 = 1'b1;
                use_rd  = 1'b1;
            end
            OP: begin
                dec_ok  = (funct3 == F3_ADD) && (funct7 == F7_ADD);
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                use_rd  = 1'b1;
                opb_sel = OPB_RS2;
            end
            LUI: begin
                dec_ok  = 1'b1;
                use_rd  = 1'b1;
                alu_op  = ALU_PASS_B;
                opb_sel = OPB_IMM_U;
            end
            AUIPC: begin
                dec_ok   = 1'b1;
                use_rd   = 1'b1;
                a_sel_pc = 1'b1;
                opb_sel  = OPB_IMM_U;
            end
            JAL: begin
                dec_ok = 1'b1;
                use_rd = 1'b1;
                is_jal = 1'b1;
            end
            JALR: begin
                dec_ok  = (funct3 == F3_ADD);
                use_rs1 = 1'b1;
                use_rd  = 1'b1;
                is_jalr = 1'b1;
            end
            SYSTEM: begin
                is_ebreak = (ir_q == INST_EBREAK);
                dec_ok    = is_ebreak;
            end
            default: ;
        endcase
    end

    // Only register fields the instruction actually uses are range-checked
    // (lui/auipc/jal carry immediate bits where rs1/rs2 would be).
    assign reg_ok = !((use_rs1 && (int'(rs1) >= NR_REGS)) ||
                      (use_rs2 && (int'(rs2) >= NR_REGS)) ||
                      (use_rd  && (int'(rd)  >= NR_REGS)));

    // Port 2 doubles as the a0 read for halt_code: whenever rs2 is not
    // needed by a legal add, it is pointed at x10.
    assign rf_raddr2 = (dec_ok && reg_ok && use_rs2) ? rs2 : 5'd10;

    ysyx_25040105_regfile #(
        .NR_REGS (NR_REGS),
        .XLEN    (XLEN)
    ) u_regfile (
        .clk       (clk),
        .we        (rf_we),
        .waddr     (rd),
        .wdata     (wb_data),
        .raddr1    (rs1),
        .rdata1    (rs1_data),
        .raddr2    (rf_raddr2),
        .rdata2    (rs2_data),
        .dbg_raddr (dbg_raddr),
        .dbg_rdata (dbg_rdata)
    );

    always_comb begin
        op_a = a_sel_pc ? pc_q : rs1_data;
        unique case (opb_sel)
            OPB_RS2:   op_b = rs2_data;
            OPB_IMM_U: op_b = imm_u;
            default:   op_b = imm_i;
        endcase
        alu_res = (alu_op == ALU_PASS_B) ? op_b : (op_a + op_b);
    end

    assign pc_plus4 = pc_q + 32'd4;
    assign jalr_sum = rs1_data + imm_i;
    assign jmp_tgt  = is_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : (pc_q + imm_j);
    assign misalign = (is_jal || is_jalr) && jmp_tgt[1];
    assign legal    = dec_ok && reg_ok && !misalign;
    assign wb_data  = (is_jal || is_jalr) ? pc_plus4 : alu_res;
    assign exec     = (state_q == ST_EXEC);
    assign rf_we    = exec && legal && use_rd;

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        ir_d           = ir_q;
        halt_illegal_d = halt_illegal_q;
        halt_code_d    = halt_code_q;
        unique case (state_q)
            ST_FETCH: begin
                if (imem_ready) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    ir_d    = imem_rdata;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (!legal || is_ebreak) begin
                    state_d        = ST_HALT;
                    halt_illegal_d = !legal;
                    halt_code_d    = rs2_data;
                end else begin
                    pc_d    = (is_jal || is_jalr) ? jmp_tgt : pc_plus4;
                    state_d = ST_FETCH;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_FETCH;
            pc_q           <= RESET_PC;
            ir_q           <= '0;
            halt_illegal_q <= 1'b0;
            halt_code_q    <= '0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            ir_q           <= ir_d;
            halt_illegal_q <= halt_illegal_d;
            halt_code_q    <= halt_code_d;
        end
    end

    assign imem_req     = (state_q == ST_FETCH);
    assign imem_addr    = pc_q;
    assign halt         = (state_q == ST_HALT);
    assign halt_illegal = halt_illegal_q;
    assign halt_code    = halt_code_q;

`ifdef YSYX_25040105_COMMIT_TRACE_EN
    // Gated so the trace reads all-zero outside the EXEC cycle.
    assign commit_valid = exec;
    assign commit_pc    = exec ? pc_q : '0;
    assign commit_inst  = exec ? ir_q : '0;
`else
    assign commit_valid = 1'b0;
    assign commit_pc    = '0;
    assign commit_inst  = '0;
`endif

endmodule
